// File: rtl/fpmul_pkg.sv
// Shared constants and payload types for the FPMUL round/pack stage.
package fpmul_pkg;

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FLG_W  = 12;
  localparam int unsigned ST_W   = 4;
  localparam int unsigned WORD_W = 32;

  localparam int unsigned FLG_P_ZF     = 11;
  localparam int unsigned FLG_P_DNF    = 10;
  localparam int unsigned FLG_P_INFF   = 9;
  localparam int unsigned FLG_P_NANF   = 8;
  localparam int unsigned FLG_MAP_ONES = 7;
  localparam int unsigned FLG_ROUND    = 6;
  localparam int unsigned FLG_UNDER    = 5;
  localparam int unsigned FLG_OVER     = 4;
  localparam int unsigned FLG_AB_NAN   = 3;
  localparam int unsigned FLG_AB_INF   = 2;
  localparam int unsigned FLG_AB_ZERO  = 1;
  localparam int unsigned FLG_AB_DNF   = 0;

  localparam int unsigned ST_NV = 3;
  localparam int unsigned ST_OF = 2;
  localparam int unsigned ST_UF = 1;
  localparam int unsigned ST_NX = 0;

  localparam logic [7:0]        EXP_MAX      = 8'hFF;
  localparam logic [WORD_W-1:0] QNAN_DEFAULT = 32'h7FC0_0000;

  // Stage-1 (post-round) payload
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_r;
    logic [FRAC_W-1:0] frac_r;
    logic [FLG_W-1:0]  flags;
    logic              round;
  } s1_t;

endpackage

// File: rtl/fpmul_pipe_ctl.sv
// Generic two-deep valid/ready pipeline controller producing per-stage load enables.
module fpmul_pipe_ctl (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready_c,
  input  logic out_ready,
  output logic s1_load_c,
  output logic s2_load_c,
  output logic s1_valid,
  output logic s2_valid
);

  logic s1_adv_c;

  // Stage 1 may move on whenever stage 2 is empty or draining this cycle
  always_comb begin
    s1_adv_c   = ~s2_valid | out_ready;
    in_ready_c = ~rst & (~s1_valid | s1_adv_c);
    s1_load_c  = in_valid & in_ready_c;
    s2_load_c  = s1_valid & s1_adv_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= s1_load_c | (s1_valid & ~s1_adv_c);
      s2_valid <= s2_load_c | (s2_valid & ~out_ready);
    end
  end

endmodule

// File: rtl/fpmul_round_pack.sv
// FPMUL final stage: round-to-nearest-even, special-case resolution, IEEE-754 packing
// and sticky exception status, as a two-stage valid/ready pipeline.
module fpmul_round_pack
  import fpmul_pkg::*;
#(
  parameter logic [WORD_W-1:0] QNAN     = QNAN_DEFAULT,
  parameter int                FLUSH_DN = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [EXP_W-1:0]  EAP,
  input  logic [FRAC_W-1:0] MAP,
  input  logic [FLG_W-1:0]  flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] result,
  output logic [ST_W-1:0]   status,
  input  logic              status_clr
);

  if (FLUSH_DN != 1) begin : g_flush_chk
    $fatal(1, "fpmul_round_pack: only FLUSH_DN=1 is supported");
  end

  logic s1_load_c, s2_load_c, s1_valid, s2_valid;

  fpmul_pipe_ctl u_ctl (
    .clk        (Clk),
    .rst        (Rst),
    .in_valid   (in_valid),
    .in_ready_c (in_ready),
    .out_ready  (out_ready),
    .s1_load_c  (s1_load_c),
    .s2_load_c  (s2_load_c),
    .s1_valid   (s1_valid),
    .s2_valid   (s2_valid)
  );

  assign out_valid = s2_valid;

  s1_t               s1_d, s1_q;
  logic [FRAC_W-1:0] frac_sum_c;
  logic              carry_c;

  // Rounding increment; a carry out of an all-ones fraction bumps the exponent
  always_comb begin
    carry_c      = flags[FLG_ROUND] & flags[FLG_MAP_ONES];
    frac_sum_c   = MAP + FRAC_W'(flags[FLG_ROUND]);
    s1_d.sign    = sign;
    s1_d.exp_r   = EAP + EXP_W'(carry_c);
    s1_d.frac_r  = carry_c ? '0 : frac_sum_c;
    s1_d.flags   = flags;
    s1_d.round   = flags[FLG_ROUND];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) s1_q <= '0;
    else if (s1_load_c) s1_q <= s1_d;
  end

  logic [WORD_W-1:0] res_c;
  logic [ST_W-1:0]   st_set_c;
  logic              under_c, over_c;

  // Special-case priority select and pack
  always_comb begin
    res_c    = {s1_q.sign, s1_q.exp_r[7:0], s1_q.frac_r};
    st_set_c = '0;
    under_c  = s1_q.flags[FLG_UNDER] | s1_q.exp_r[9] | (s1_q.exp_r[7:0] == 8'h00);
    over_c   = s1_q.flags[FLG_OVER] | s1_q.exp_r[8] | (s1_q.exp_r[7:0] == EXP_MAX);
    if (s1_q.flags[FLG_AB_NAN]) begin
      res_c           = QNAN;
      st_set_c[ST_NV] = 1'b1;
    end else if (s1_q.flags[FLG_AB_INF]) begin
      res_c = {s1_q.sign, EXP_MAX, FRAC_W'(0)};
    end else if (s1_q.flags[FLG_AB_ZERO] | s1_q.flags[FLG_AB_DNF]) begin
      res_c = {s1_q.sign, 31'h0};
    end else if (under_c) begin
      res_c           = {s1_q.sign, 31'h0};
      st_set_c[ST_UF] = 1'b1;
      st_set_c[ST_NX] = 1'b1;
    end else if (over_c) begin
      res_c           = {s1_q.sign, EXP_MAX, FRAC_W'(0)};
      st_set_c[ST_OF] = 1'b1;
      st_set_c[ST_NX] = 1'b1;
    end else begin
      st_set_c[ST_NX] = s1_q.round;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      result <= '0;
      status <= '0;
    end else begin
      if (s2_load_c) result <= res_c;
      status <= (status_clr ? '0 : status) | (s2_load_c ? st_set_c : '0);
    end
  end

  // Product-side classification flags are carried for visibility but not consumed here
  logic unused_flag_bits;
  assign unused_flag_bits = ^{s1_q.flags[FLG_P_ZF:FLG_ROUND]};

endmodule
